// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, funcs, ALU codes,
// FSM states and the instruction classifier used by the decode logic.
package mc_control_fsm_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  localparam logic [3:0] OP_BNE = 4'd0;
  localparam logic [3:0] OP_BEQ = 4'd1;
  localparam logic [3:0] OP_BGZ = 4'd2;
  localparam logic [3:0] OP_BLZ = 4'd3;
  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_ALU = 4'd15;

  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_AND = 6'd2;
  localparam logic [5:0] FN_ORR = 6'd3;
  localparam logic [5:0] FN_NOT = 6'd4;
  localparam logic [5:0] FN_TCP = 6'd5;
  localparam logic [5:0] FN_SHL = 6'd6;
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  // ALU codes 0..7 deliberately equal the R-type func values
  localparam logic [3:0] FUNC_ADD = 4'd0;
  localparam logic [3:0] FUNC_SUB = 4'd1;
  localparam logic [3:0] FUNC_AND = 4'd2;
  localparam logic [3:0] FUNC_ORR = 4'd3;
  localparam logic [3:0] FUNC_NOT = 4'd4;
  localparam logic [3:0] FUNC_TCP = 4'd5;
  localparam logic [3:0] FUNC_SHL = 4'd6;
  localparam logic [3:0] FUNC_SHR = 4'd7;
  localparam logic [3:0] FUNC_LHI = 4'd8;
  localparam logic [3:0] FUNC_BNE = 4'd9;
  localparam logic [3:0] FUNC_BEQ = 4'd10;
  localparam logic [3:0] FUNC_BGZ = 4'd11;
  localparam logic [3:0] FUNC_BLZ = 4'd12;

  typedef enum logic [3:0] {
    C_RTYPE, C_ADI, C_ORI, C_LHI, C_LWD, C_SWD, C_BRANCH,
    C_JMP, C_JAL, C_JPR, C_JRL, C_WWD, C_HLT, C_UNDEF
  } inst_e;

  function automatic inst_e classify(input logic [3:0] opc, input logic [5:0] fn);
    inst_e c;
    c = C_UNDEF;
    case (opc)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: c = C_BRANCH;
      OP_ADI: c = C_ADI;
      OP_ORI: c = C_ORI;
      OP_LHI: c = C_LHI;
      OP_LWD: c = C_LWD;
      OP_SWD: c = C_SWD;
      OP_JMP: c = C_JMP;
      OP_JAL: c = C_JAL;
      OP_ALU: begin
        case (fn)
          FN_ADD, FN_SUB, FN_AND, FN_ORR,
          FN_NOT, FN_TCP, FN_SHL, FN_SHR: c = C_RTYPE;
          FN_JPR: c = C_JPR;
          FN_JRL: c = C_JRL;
          FN_WWD: c = C_WWD;
          FN_HLT: c = C_HLT;
          default: c = C_UNDEF;
        endcase
      end
      default: c = C_UNDEF;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] branch_alu(input logic [3:0] opc);
    logic [3:0] code;
    case (opc)
      OP_BNE:  code = FUNC_BNE;
      OP_BEQ:  code = FUNC_BEQ;
      OP_BGZ:  code = FUNC_BGZ;
      default: code = FUNC_BLZ;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// Memory completion generator: mem_ready handshake when MEM_LAT=0, otherwise a
// fixed MEM_LAT-cycle wait per memory state.
module mem_wait_ctr #(
  parameter int MEM_LAT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_mem,
  input  logic mem_ready,
  output logic done
);

  generate
    if (MEM_LAT == 0) begin : g_handshake
      logic unused_ok;
      assign unused_ok = ^{clk, rst_n, in_mem};
      assign done      = mem_ready;
    end else begin : g_fixed
      localparam int CW = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          unused_ok;

      assign unused_ok = mem_ready;
      assign done      = (cnt_q == CW'(MEM_LAT - 1));

      // Counter is zero whenever a memory state is entered, since leaving one
      // (done) or being outside one both clear it.
      always_comb begin
        cnt_d = '0;
        if (in_mem && !done) cnt_d = cnt_q + CW'(1);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end
    end
  endgenerate

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control unit for the 16-bit TSC CPU (IF/ID/EX/MEM/WB/HALT).
// Optional retired-instruction counter enabled by macro CTRL_INST_COUNT_EN.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16,
  parameter int MEM_LAT = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         opcode,
  input  logic [5:0]         func,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_source,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         wb_sel,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               out_port_en,
  output logic               is_halted,
  output logic [CNT_W-1:0]   num_inst
);

  state_e state_q, state_d;
  inst_e  cls;
  logic   done;

  assign cls = classify(opcode, func);

  mem_wait_ctr #(.MEM_LAT(MEM_LAT)) u_wait (
    .clk       (clk),
    .rst_n     (reset_n),
    .in_mem    ((state_q == S_IF) || (state_q == S_MEM)),
    .mem_ready (mem_ready),
    .done      (done)
  );

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 2'b00;
    wb_sel        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = ALUOP_W'(FUNC_ADD);
    out_port_en   = 1'b0;
    is_halted     = 1'b0;
    case (state_q)
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (done) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_ID;
        end
      end
      S_ID: begin
        alu_src_b = 2'b10;
        case (cls)
          C_JMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
            state_d   = S_IF;
          end
          C_JAL: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
            reg_write = 1'b1;
            reg_dst   = 2'b10;
            wb_sel    = 2'b10;
            state_d   = S_IF;
          end
          C_HLT:   state_d = S_HALT;
          C_UNDEF: state_d = S_IF;
          default: state_d = S_EX;
        endcase
      end
      S_EX: begin
        alu_src_a = 1'b1;
        case (cls)
          C_RTYPE: begin
            alu_op  = ALUOP_W'({1'b0, func[2:0]});
            state_d = S_WB;
          end
          C_ADI: begin
            alu_src_b = 2'b10;
            state_d   = S_WB;
          end
          C_LWD, C_SWD: begin
            alu_src_b = 2'b10;
            state_d   = S_MEM;
          end
          C_ORI: begin
            alu_src_b = 2'b11;
            alu_op    = ALUOP_W'(FUNC_ORR);
            state_d   = S_WB;
          end
          C_LHI: begin
            alu_src_b = 2'b10;
            alu_op    = ALUOP_W'(FUNC_LHI);
            state_d   = S_WB;
          end
          C_BRANCH: begin
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            alu_op        = ALUOP_W'(branch_alu(opcode));
            state_d       = S_IF;
          end
          C_JPR: begin
            pc_write  = 1'b1;
            pc_source = 2'b11;
            state_d   = S_IF;
          end
          C_JRL: begin
            pc_write  = 1'b1;
            pc_source = 2'b11;
            reg_write = 1'b1;
            reg_dst   = 2'b10;
            wb_sel    = 2'b10;
            state_d   = S_IF;
          end
          C_WWD: begin
            out_port_en = 1'b1;
            state_d     = S_IF;
          end
          default: state_d = S_IF;
        endcase
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = (cls == C_LWD);
        mem_write = (cls == C_SWD);
        if (done) state_d = (cls == C_LWD) ? S_WB : S_IF;
      end
      S_WB: begin
        reg_write = 1'b1;
        reg_dst   = (cls == C_RTYPE) ? 2'b00 : 2'b01;
        wb_sel    = (cls == C_LWD) ? 2'b01 : 2'b00;
        state_d   = S_IF;
      end
      S_HALT: is_halted = 1'b1;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IF;
    else          state_q <= state_d;
  end

`ifdef CTRL_INST_COUNT_EN
  logic [CNT_W-1:0] num_inst_q, num_inst_d;

  // A retire is any entry into IF from another state; IF stalls do not count.
  always_comb begin
    num_inst_d = num_inst_q;
    if ((state_d == S_IF) && (state_q != S_IF)) num_inst_d = num_inst_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) num_inst_q <= '0;
    else          num_inst_q <= num_inst_d;
  end

  assign num_inst = num_inst_q;
`else
  assign num_inst = '0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed scoreboard bench for mc_control_fsm: one MEM_LAT=0 and one MEM_LAT=3 instance.
module tb_mc_control_fsm;
  import mc_control_fsm_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] opcode = OP_ALU;
  logic [5:0] func = FN_ADD;
  logic       mem_ready = 1'b1;

  logic       pw [2], pwc [2], iod [2], mr [2], mw [2], irw [2], rw [2], asa [2], ope [2], hlt [2];
  logic [1:0] ps [2], rd [2], wbs [2], asb [2];
  logic [3:0] aop [2];
  logic [15:0] ni [2];

  always #5 clk = ~clk;

  mc_control_fsm #(.ALUOP_W(4), .CNT_W(16), .MEM_LAT(0)) d0 (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .func(func), .mem_ready(mem_ready),
    .pc_write(pw[0]), .pc_write_cond(pwc[0]), .pc_source(ps[0]), .i_or_d(iod[0]),
    .mem_read(mr[0]), .mem_write(mw[0]), .ir_write(irw[0]), .reg_write(rw[0]),
    .reg_dst(rd[0]), .wb_sel(wbs[0]), .alu_src_a(asa[0]), .alu_src_b(asb[0]),
    .alu_op(aop[0]), .out_port_en(ope[0]), .is_halted(hlt[0]), .num_inst(ni[0]));

  mc_control_fsm #(.ALUOP_W(4), .CNT_W(16), .MEM_LAT(3)) d3 (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .func(func), .mem_ready(mem_ready),
    .pc_write(pw[1]), .pc_write_cond(pwc[1]), .pc_source(ps[1]), .i_or_d(iod[1]),
    .mem_read(mr[1]), .mem_write(mw[1]), .ir_write(irw[1]), .reg_write(rw[1]),
    .reg_dst(rd[1]), .wb_sel(wbs[1]), .alu_src_a(asa[1]), .alu_src_b(asb[1]),
    .alu_op(aop[1]), .out_port_en(ope[1]), .is_halted(hlt[1]), .num_inst(ni[1]));

  localparam logic [21:0] B_PW  = 22'd1 << 21;
  localparam logic [21:0] B_PWC = 22'd1 << 20;
  localparam logic [21:0] B_IOD = 22'd1 << 17;
  localparam logic [21:0] B_MR  = 22'd1 << 16;
  localparam logic [21:0] B_MW  = 22'd1 << 15;
  localparam logic [21:0] B_IRW = 22'd1 << 14;
  localparam logic [21:0] B_RW  = 22'd1 << 13;
  localparam logic [21:0] B_ASA = 22'd1 << 8;
  localparam logic [21:0] B_OPE = 22'd1 << 1;
  localparam logic [21:0] B_HLT = 22'd1;
  localparam logic [21:0] NO_A  = ~B_ASA;
  localparam logic [21:0] ALL   = '1;

  function automatic logic [21:0] f_ps(input logic [1:0] x); return 22'(x) << 18; endfunction
  function automatic logic [21:0] f_rd(input logic [1:0] x); return 22'(x) << 11; endfunction
  function automatic logic [21:0] f_wb(input logic [1:0] x); return 22'(x) << 9;  endfunction
  function automatic logic [21:0] f_sb(input logic [1:0] x); return 22'(x) << 6;  endfunction
  function automatic logic [21:0] f_op(input logic [3:0] x); return 22'(x) << 2;  endfunction

  function automatic logic [21:0] ctl_of(input int k);
    return {pw[k], pwc[k], ps[k], iod[k], mr[k], mw[k], irw[k], rw[k],
            rd[k], wbs[k], asa[k], asb[k], aop[k], ope[k], hlt[k]};
  endfunction

  function automatic logic [3:0] br_code(input int b);
    case (b)
      0:       return FUNC_BNE;
      1:       return FUNC_BEQ;
      2:       return FUNC_BGZ;
      default: return FUNC_BLZ;
    endcase
  endfunction

  localparam logic [21:0] V_IF0 = B_MR | (22'd1 << 6);
  localparam logic [21:0] V_IF1 = V_IF0 | B_IRW | B_PW;
  localparam logic [21:0] V_ID  = 22'd2 << 6;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    logic [31:0] care;
  } sb_t;

  sb_t sbq[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  step    = 0;
  int  n_ret   = 0;

  task automatic exp_c(input int k, input logic [21:0] e, input logic [21:0] c);
    sb_t s;
    s.kind = k; s.exp = {10'b0, e}; s.care = {10'b0, c};
    sbq.push_back(s);
  endtask

  task automatic exp_n(input int k, input int v);
    sb_t s;
    s.kind = k + 2;
`ifdef CTRL_INST_COUNT_EN
    s.exp = 32'(v) & 32'hFFFF;
`else
    s.exp = (v > 0) ? 32'd0 : 32'd0;
`endif
    s.care = 32'hFFFF;
    sbq.push_back(s);
  endtask

  // Compare everything queued for this cycle at the falling edge, then move
  // to just after the next rising edge where the next stimulus is applied.
  task automatic cyc();
    @(negedge clk);
    step++;
    while (sbq.size() > 0) begin
      sb_t s;
      logic [31:0] obs;
      s = sbq.pop_front();
      obs = (s.kind < 2) ? {10'b0, ctl_of(s.kind)} : {16'b0, ni[s.kind - 2]};
      n_tests++;
      assert ((obs & s.care) === (s.exp & s.care))
      else begin
        n_fail++;
        $error("FAIL step%0d kind%0d observed=%h expected=%h", step, s.kind, obs & s.care, s.exp & s.care);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic [3:0] o, input logic [5:0] f);
    opcode = o;
    func   = f;
  endtask

  task automatic fetch0();
    mem_ready = 1'b1;
    exp_c(0, V_IF1, ALL);
    exp_n(0, n_ret);
    cyc();
    exp_c(0, V_ID, ALL);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk);
    #1;
    exp_c(0, V_IF1, ALL);
    exp_c(1, V_IF0, ALL);
    exp_n(0, 0);
    exp_n(1, 0);
    cyc();
    reset_n = 1'b1;

    for (int f = 0; f < 8; f++) begin
      set_inst(OP_ALU, 6'(f));
      fetch0();
      exp_c(0, B_ASA | f_op(4'(f)), ALL);
      cyc();
      exp_c(0, B_RW, ALL);
      cyc();
      n_ret++;
    end

    set_inst(OP_ALU, FN_SUB);
    mem_ready = 1'b0;
    exp_n(0, n_ret);
    for (int i = 0; i < 3; i++) begin
      exp_c(0, V_IF0, ALL);
      cyc();
    end
    mem_ready = 1'b1;
    exp_c(0, V_IF1, ALL); cyc();
    exp_c(0, V_ID, ALL); cyc();
    exp_c(0, B_ASA | f_op(FUNC_SUB), ALL); cyc();
    exp_c(0, B_RW, ALL); cyc();
    n_ret++;

    set_inst(OP_ADI, 6'd0); fetch0();
    exp_c(0, f_sb(2'b10), NO_A); cyc();
    exp_c(0, B_RW | f_rd(2'b01), ALL); cyc();
    n_ret++;

    set_inst(OP_ORI, 6'd0); fetch0();
    exp_c(0, f_sb(2'b11) | f_op(FUNC_ORR), NO_A); cyc();
    exp_c(0, B_RW | f_rd(2'b01), ALL); cyc();
    n_ret++;

    set_inst(OP_LHI, 6'd0); fetch0();
    exp_c(0, f_sb(2'b10) | f_op(FUNC_LHI), NO_A); cyc();
    exp_c(0, B_RW | f_rd(2'b01), ALL); cyc();
    n_ret++;

    set_inst(OP_LWD, 6'd0); fetch0();
    exp_c(0, f_sb(2'b10), NO_A); cyc();
    exp_c(0, B_IOD | B_MR, ALL); cyc();
    exp_c(0, B_RW | f_rd(2'b01) | f_wb(2'b01), ALL); cyc();
    n_ret++;

    set_inst(OP_SWD, 6'd0); fetch0();
    exp_c(0, f_sb(2'b10), NO_A); cyc();
    exp_c(0, B_IOD | B_MW, ALL); cyc();
    n_ret++;

    for (int b = 0; b < 4; b++) begin
      set_inst(4'(b), 6'd0); fetch0();
      exp_c(0, B_PWC | f_ps(2'b01) | f_op(br_code(b)), NO_A); cyc();
      n_ret++;
    end

    set_inst(OP_ALU, FN_JPR); fetch0();
    exp_c(0, B_PW | f_ps(2'b11), NO_A); cyc();
    n_ret++;

    set_inst(OP_ALU, FN_JRL); fetch0();
    exp_c(0, B_PW | f_ps(2'b11) | B_RW | f_rd(2'b10) | f_wb(2'b10), NO_A); cyc();
    n_ret++;

    set_inst(OP_ALU, FN_WWD); fetch0();
    exp_c(0, B_OPE, NO_A); cyc();
    n_ret++;

    set_inst(OP_JMP, 6'd0);
    exp_c(0, V_IF1, ALL); exp_n(0, n_ret); cyc();
    exp_c(0, V_ID | B_PW | f_ps(2'b10), ALL); cyc();
    n_ret++;

    set_inst(OP_JAL, 6'd0);
    exp_c(0, V_IF1, ALL); exp_n(0, n_ret); cyc();
    exp_c(0, V_ID | B_PW | f_ps(2'b10) | B_RW | f_rd(2'b10) | f_wb(2'b10), ALL); cyc();
    n_ret++;

    set_inst(4'd12, 6'd0); fetch0();
    n_ret++;
    set_inst(OP_ALU, 6'd40); fetch0();
    n_ret++;

    set_inst(OP_SWD, 6'd0); fetch0();
    exp_c(0, f_sb(2'b10), NO_A); cyc();
    mem_ready = 1'b0;
    exp_c(0, B_IOD | B_MW, ALL); cyc();
    exp_c(0, B_IOD | B_MW, ALL); cyc();
    reset_n = 1'b0;
    n_ret = 0;
    exp_c(0, V_IF0, ALL); exp_n(0, 0); cyc();
    mem_ready = 1'b1;
    exp_c(0, V_IF1, ALL); exp_c(1, V_IF0, ALL); exp_n(1, 0); cyc();
    reset_n = 1'b1;

    set_inst(OP_LWD, 6'd0);
    exp_c(1, V_IF0, ALL); cyc();
    exp_c(1, V_IF0, ALL); cyc();
    exp_c(1, V_IF1, ALL); cyc();
    exp_c(1, V_ID, ALL); cyc();
    exp_c(1, f_sb(2'b10), NO_A); cyc();
    for (int i = 0; i < 3; i++) begin
      exp_c(1, B_IOD | B_MR, ALL); cyc();
    end
    exp_c(1, B_RW | f_rd(2'b01) | f_wb(2'b01), ALL); cyc();
    exp_c(1, V_IF0, ALL); exp_n(1, 1); cyc();

    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    n_ret = 0;
    for (int i = 0; i < 2; i++) begin
      set_inst(OP_ADI, 6'd0); fetch0();
      exp_c(0, f_sb(2'b10), NO_A); cyc();
      exp_c(0, B_RW | f_rd(2'b01), ALL); cyc();
      n_ret++;
    end
    set_inst(OP_ALU, FN_HLT); fetch0();
    set_inst(OP_ALU, FN_ADD);
    for (int i = 0; i < 5; i++) begin
      mem_ready = i[0];
      exp_c(0, B_HLT, ALL); exp_n(0, 2); cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
